convo_line_fifo: RTL and testbench
==================================

// Module: convo_line_fifo
// PURPOSE
//  Line-buffer FIFO that answers the convolution FIFO controller's ff_* command set.
//  Writes one pixel per ff_wen; on ff_ren it reads one pixel and advances the read pointer by ff_stride.
//  This lets the controller skip pixels for the horizontal stride and jump over the row tail.
//  Sits between the feature-map loader and the convolution window/MAC stage.
// PARAMETERS
//  DATA_W  8   pixel width in bits
//  DEPTH   32  entries; power of two, >= max row_len (5-bit row_len)
//  ADDR_W  5   log2(DEPTH); pointer width
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  ff_rst      in   1       synchronous soft clear from controller
//  ff_wen      in   1       write strobe
//  ff_ren      in   1       read strobe
//  ff_stride   in   3       read-pointer advance per accepted read (0 treated as 1)
//  ff_row_len  in   5       row length; sampled on ff_rst
//  din         in   DATA_W  write data
//  dout        out  DATA_W  registered read data
//  dout_valid  out  1       dout updated this cycle
//  empty       out  1       count == 0
//  full        out  1       count == DEPTH
//  row_ready   out  1       count >= latched row_len
//  count       out  ADDR_W+1  occupancy
//  ovf, udf    out  1       sticky error flags (only with CONVO_FIFO_ERR_EN)
// BEHAVIOUR
//  - rst (async): wptr=rptr=0, count=0, dout=0, dout_valid=0, row_len_q=0, ovf=udf=0.
//    Outputs: empty=1, full=0, row_ready=1 (0>=0).
//  - ff_rst (sync) overrides wen/ren in the same cycle.
//    Clears wptr, rptr, count, dout_valid and flags; dout holds its value; row_len_q<=ff_row_len.
//  - adv = (ff_stride==0) ? 1 : ff_stride (zero-extended to ADDR_W+1).
//  - Write accepted: ff_wen && !full.
//    Effect: mem[wptr]<=din; wptr<=wptr+1 (mod DEPTH wrap).
//  - Read accepted: ff_ren && count >= adv.
//    Effect: dout<=mem[rptr]; dout_valid<=1 next cycle; rptr<=rptr+adv (mod DEPTH).
//    Skipped entries are discarded.
//  - Read not accepted: dout holds; dout_valid<=0.
//  - Latency: read data appears 1 cycle after the accepted ff_ren edge.
//  - count_next = count + wacc - (racc ? adv : 0).
//  - Simultaneous wen+ren: the read uses pre-write count and pointers, so write-through is impossible.
//    With full && ren && wen: the write is rejected even if the read frees space (full is the registered flag).
//  - empty/full/row_ready are combinational decodes of registered count; no extra latency.
//  - Pointer arithmetic wraps naturally at ADDR_W bits; count never exceeds DEPTH.
//  - No internal FSM states beyond the pointers, count and flags. Fully synchronous apart from rst.
// CONFIGURATION
//  CONVO_FIFO_ERR_EN defined: ovf and udf ports exist.
//   - ovf sets on ff_wen && full; udf sets on ff_ren && count < adv.
//   - Both are sticky until rst or ff_rst.
//  CONVO_FIFO_ERR_EN undefined: ports omitted; rejected writes and reads are dropped silently.
// TESTING
//  1. rst mid-stream with count=5 -> same cycle count=0, empty=1, dout=0, dout_valid=0.
//  2. ff_rst with row_len=8; write 0..9 -> row_ready rises at count=8; full=0.
//     Then ren with stride=1 -> dout=0 one cycle later, count=9.
//  3. Fill 0..31, ren with stride=2 x3 -> dout=0,2,4; count=26.
//     Then stride=3 -> dout=6, count=23, rptr=9.
//  4. full=1, wen+ren with stride=1 -> write dropped, dout=oldest, count=31.
//     With ERR_EN: ovf=1.
//  5. count=2, ren with stride=3 -> no read, dout_valid=0, count=2.
//     With ERR_EN: udf=1; a following ff_rst clears udf.
//  6. Wrap: 40 interleaved wen/ren with stride=1 -> dout is exactly 0..39 in order; count is constant.
//     ff_stride=0 behaves as 1.

Source files
------------

// File: rtl/convo_line_fifo.sv
// Strided line-buffer FIFO for the convolution FIFO controller (ff_* command set).
// Define CONVO_FIFO_ERR_EN to add the sticky ovf/udf error flags.
module convo_line_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ff_rst,
  input  logic              ff_wen,
  input  logic              ff_ren,
  input  logic [2:0]        ff_stride,
  input  logic [4:0]        ff_row_len,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic              row_ready,
  output logic [ADDR_W:0]   count
`ifdef CONVO_FIFO_ERR_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [4:0]        row_len_q;
  logic [ADDR_W:0]   adv;
  logic              wacc;
  logic              racc;

  // A zero stride still consumes one pixel so the controller can never stall the read side.
  assign adv       = (ff_stride == 3'd0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(ff_stride);
  assign empty     = (count == '0);
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign row_ready = (count >= (ADDR_W+1)'(row_len_q));
  assign wacc      = ff_wen && !full;
  assign racc      = ff_ren && (count >= adv);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      row_len_q  <= '0;
    end else if (ff_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      row_len_q  <= ff_row_len;
    end else begin
      if (wacc) wptr <= wptr + ADDR_W'(1);
      if (racc) begin
        dout       <= mem[rptr];
        dout_valid <= 1'b1;
        rptr       <= rptr + adv[ADDR_W-1:0];
      end else begin
        dout_valid <= 1'b0;
      end
      count <= count + (ADDR_W+1)'(wacc) - (racc ? adv : '0);
    end
  end

  // NOTE: the pixel array has no reset; occupancy tracking guarantees stale words are never read.
  always_ff @(posedge clk) begin
    if (wacc && !ff_rst) mem[wptr] <= din;
  end

`ifdef CONVO_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (ff_rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ff_wen && full)         ovf <= 1'b1;
      if (ff_ren && count < adv)  udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_convo_line_fifo.sv
// Self-checking bench for convo_line_fifo: queue-based model plus read-data scoreboard.
// Build with CONVO_FIFO_ERR_EN defined to also exercise the ovf/udf flags.
module tb_convo_line_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ff_rst;
  logic              ff_wen;
  logic              ff_ren;
  logic [2:0]        ff_stride;
  logic [4:0]        ff_row_len;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic              row_ready;
  logic [ADDR_W:0]   count;
`ifdef CONVO_FIFO_ERR_EN
  logic              ovf;
  logic              udf;
`endif

  convo_line_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ff_rst(ff_rst), .ff_wen(ff_wen), .ff_ren(ff_ren),
    .ff_stride(ff_stride), .ff_row_len(ff_row_len), .din(din), .dout(dout),
    .dout_valid(dout_valid), .empty(empty), .full(full), .row_ready(row_ready),
    .count(count)
`ifdef CONVO_FIFO_ERR_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] m_dout;
  bit                m_valid;
  int                m_row_len;
  bit                m_ovf;
  bit                m_udf;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},       32'(dout),       32'(m_dout));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, ".count"},      32'(count),      mq.size());
    check({tag, ".empty"},      32'(empty),      32'(mq.size() == 0));
    check({tag, ".full"},       32'(full),       32'(mq.size() == DEPTH));
    check({tag, ".row_ready"},  32'(row_ready),  32'(mq.size() >= m_row_len));
`ifdef CONVO_FIFO_ERR_EN
    check({tag, ".ovf"},        32'(ovf),        32'(m_ovf));
    check({tag, ".udf"},        32'(udf),        32'(m_udf));
`endif
  endtask

  // One clock cycle of stimulus; the model predicts the result and the scoreboard queue carries read data.
  task automatic step(input string tag, input bit rs, input bit w, input bit r,
                      input logic [2:0] st, input logic [7:0] d, input logic [4:0] rl);
    int  adv;
    bit  was_full;
    ff_rst = rs; ff_wen = w; ff_ren = r; ff_stride = st; din = d; ff_row_len = rl;
    adv      = (st == 3'd0) ? 1 : int'(st);
    was_full = (mq.size() == DEPTH);
    if (rs) begin
      mq.delete();
      m_valid   = 1'b0;
      m_row_len = int'(rl);
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (r) begin
        if (mq.size() >= adv) begin
          exp_q.push_back(mq[0]);
          for (int i = 0; i < adv; i++) void'(mq.pop_front());
          m_valid = 1'b1;
        end else begin
          m_udf = 1'b1;
        end
      end
      if (w) begin
        if (!was_full) mq.push_back(d);
        else           m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL %s.scoreboard: empty queue on expected read", tag);
      end else begin
        m_dout = exp_q.pop_front();
      end
    end
    check_outputs(tag);
    ff_rst = 1'b0; ff_wen = 1'b0; ff_ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ff_rst = 1'b0; ff_wen = 1'b0; ff_ren = 1'b0;
    ff_stride = 3'd1; ff_row_len = 5'd0; din = '0;
    m_dout = '0; m_valid = 1'b0; m_row_len = 0; m_ovf = 1'b0; m_udf = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // 1. async reset in the middle of a stream
    for (int i = 0; i < 6; i++) step("t1_wr", 0, 1, 0, 3'd1, 8'(i + 100), 5'd0);
    step("t1_rd", 0, 0, 1, 3'd1, 8'd0, 5'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    mq.delete(); exp_q.delete();
    m_dout = '0; m_valid = 1'b0; m_row_len = 0; m_ovf = 1'b0; m_udf = 1'b0;
    check_outputs("t1_async_rst");
    @(negedge clk); rst = 1'b0;

    // 2. row_ready threshold; ff_rst overrides a simultaneous write
    step("t2_ffrst", 1, 1, 1, 3'd1, 8'hAA, 5'd8);
    for (int i = 0; i < 10; i++) step("t2_wr", 0, 1, 0, 3'd1, 8'(i), 5'd0);
    step("t2_rd", 0, 0, 1, 3'd1, 8'd0, 5'd0);

    // 3. strided reads from a full buffer
    step("t3_ffrst", 1, 0, 0, 3'd1, 8'd0, 5'd0);
    for (int i = 0; i < 32; i++) step("t3_fill", 0, 1, 0, 3'd1, 8'(i), 5'd0);
    for (int i = 0; i < 3; i++) step("t3_s2", 0, 0, 1, 3'd2, 8'd0, 5'd0);
    step("t3_s3", 0, 0, 1, 3'd3, 8'd0, 5'd0);
    step("t3_s1", 0, 0, 1, 3'd1, 8'd0, 5'd0);

    // 4. full with simultaneous write and read: write is rejected
    step("t4_ffrst", 1, 0, 0, 3'd1, 8'd0, 5'd0);
    for (int i = 0; i < 32; i++) step("t4_fill", 0, 1, 0, 3'd1, 8'(i + 50), 5'd0);
    step("t4_wr_rd", 0, 1, 1, 3'd1, 8'hEE, 5'd0);

    // 5. underflow on a stride larger than occupancy, then ff_rst clears it
    step("t5_ffrst", 1, 0, 0, 3'd1, 8'd0, 5'd0);
    step("t5_wr", 0, 1, 0, 3'd1, 8'd7, 5'd0);
    step("t5_wr", 0, 1, 0, 3'd1, 8'd8, 5'd0);
    step("t5_udf", 0, 0, 1, 3'd3, 8'd0, 5'd0);
    step("t5_ffrst2", 1, 0, 0, 3'd1, 8'd0, 5'd4);

    // 6. pointer wrap with streaming write+read; stride 0 alternates with stride 1
    step("t6_ffrst", 1, 0, 0, 3'd1, 8'd0, 5'd1);
    step("t6_prime", 0, 1, 0, 3'd1, 8'd0, 5'd0);
    for (int i = 0; i < 40; i++)
      step("t6_stream", 0, 1, 1, (i % 2 == 0) ? 3'd0 : 3'd1, 8'(i + 1), 5'd0);

    // Random mix of all commands
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
           8'($urandom), 5'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
